// File: rtl/ser_des_pkg.sv
// Definitions shared by the serializer and deserializer ends of the narrow link:
// the output-register state encoding and the chunk-counter width helper.
package ser_des_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // A counter needs at least one bit even when a word is a single chunk pair.
    function automatic int chunk_cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/shift_deserializer.sv
// Reassembles FROM-bit words from a stream of TO-bit chunks (first chunk lands in the
// top slice) and presents each word on a single-entry valid/ready output register.
module shift_deserializer
    import ser_des_pkg::*;
#(
    parameter int FROM = 32,
    parameter int TO   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [TO-1:0]   data_i,
    input  logic            valid_i,
    input  logic            flush_i,
    output logic [FROM-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            overflow_o,
    output logic            busy_o
);

    localparam int N     = FROM / TO;
    localparam int CNT_W = chunk_cnt_w(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (FROM % TO != 0) begin : g_bad_ratio
        $error("shift_deserializer: FROM must be a multiple of TO");
    end
    if (TO >= FROM) begin : g_bad_width
        $error("shift_deserializer: TO must be smaller than FROM");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FROM-1:0]  sr_q, sr_d;
    logic [FROM-1:0]  data_q, data_d;
    logic             ovf_q, ovf_d;
    out_state_e       state_q, state_d;

    logic [FROM-1:0]  shifted;
    logic             word_done;

    assign shifted = {sr_q[FROM-TO-1:0], data_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= EMPTY;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    // Assembly side: flush discards any chunk presented in the same cycle.
    always_comb begin
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        word_done = 1'b0;
        if (flush_i) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (valid_i) begin
            sr_d = shifted;
            if (cnt_q == LAST_CNT) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output side: a completion while the held word is not being consumed is dropped.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = flush_i ? 1'b0 : ovf_q;
        case (state_q)
            EMPTY: begin
                if (word_done) begin
                    state_d = FULL;
                    data_d  = shifted;
                end
            end
            FULL: begin
                if (word_done) begin
                    if (ready_i) begin
                        data_d = shifted;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign data_o     = data_q;
    assign valid_o    = (state_q == FULL);
    assign overflow_o = ovf_q;
    assign busy_o     = (cnt_q != '0);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench: an 8/2 instance driven from a vector table plus hand-written
// sequences, and a 32/4 instance for overflow and same-cycle handshake corners.
module tb_shift_deserializer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FROM=8, TO=2 instance
    logic [1:0]  d8_data;
    logic        d8_valid, d8_flush, d8_ready;
    logic [7:0]  d8_out;
    logic        d8_vo, d8_ovf, d8_busy;

    // FROM=32, TO=4 instance
    logic [3:0]  d32_data;
    logic        d32_valid, d32_flush, d32_ready;
    logic [31:0] d32_out;
    logic        d32_vo, d32_ovf, d32_busy;

    shift_deserializer #(.FROM(8), .TO(2)) u_d8 (
        .clk(clk), .reset(reset), .data_i(d8_data), .valid_i(d8_valid),
        .flush_i(d8_flush), .data_o(d8_out), .valid_o(d8_vo),
        .ready_i(d8_ready), .overflow_o(d8_ovf), .busy_o(d8_busy)
    );

    shift_deserializer #(.FROM(32), .TO(4)) u_d32 (
        .clk(clk), .reset(reset), .data_i(d32_data), .valid_i(d32_valid),
        .flush_i(d32_flush), .data_o(d32_out), .valid_o(d32_vo),
        .ready_i(d32_ready), .overflow_o(d32_ovf), .busy_o(d32_busy)
    );

    typedef struct {
        logic       valid;
        logic       flush;
        logic       ready;
        logic [1:0] data;
        logic       exp_valid;
        logic       exp_busy;
        logic       exp_ovf;
        logic       chk_data;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic f, input logic r, input logic [1:0] d,
                       input logic ev, input logic eb, input logic eo, input logic cd,
                       input logic [7:0] ed);
        vec_t t;
        t.valid = v; t.flush = f; t.ready = r; t.data = d;
        t.exp_valid = ev; t.exp_busy = eb; t.exp_ovf = eo; t.chk_data = cd; t.exp_data = ed;
        vecs.push_back(t);
    endtask

    // Each cycle task is entered at a negedge and returns at the following negedge.
    task automatic cyc8(input logic v, input logic [1:0] d, input logic r);
        d8_valid = v; d8_data = d; d8_ready = r; d8_flush = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic cyc32(input logic v, input logic [3:0] d, input logic r, input logic f);
        d32_valid = v; d32_data = d; d32_ready = r; d32_flush = f;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        d8_data = '0;  d8_valid = 0;  d8_flush = 0;  d8_ready = 0;
        d32_data = '0; d32_valid = 0; d32_flush = 0; d32_ready = 0;
        repeat (2) @(negedge clk);

        check("rst_d8_data",  {24'd0, d8_out}, 32'h0);
        check("rst_d8_valid", {31'd0, d8_vo},  32'h0);
        check("rst_d8_ovf",   {31'd0, d8_ovf}, 32'h0);
        check("rst_d8_busy",  {31'd0, d8_busy}, 32'h0);
        check("rst_d32_data", d32_out, 32'h0);
        check("rst_d32_valid", {31'd0, d32_vo}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // chunks 11,01,10,00 -> D8, valid for one cycle
        add(1,0,1,2'd3, 0,1,0,0,8'h00);
        add(1,0,1,2'd1, 0,1,0,0,8'h00);
        add(1,0,1,2'd2, 0,1,0,0,8'h00);
        add(1,0,1,2'd0, 1,0,0,1,8'hD8);
        add(0,0,1,2'd0, 0,0,0,1,8'hD8);
        // same word with a 3-cycle gap after chunk 1
        add(1,0,1,2'd3, 0,1,0,0,8'h00);
        add(1,0,1,2'd1, 0,1,0,0,8'h00);
        add(0,0,1,2'd0, 0,1,0,0,8'h00);
        add(0,0,1,2'd0, 0,1,0,0,8'h00);
        add(0,0,1,2'd0, 0,1,0,0,8'h00);
        add(1,0,1,2'd2, 0,1,0,0,8'h00);
        add(1,0,1,2'd0, 1,0,0,1,8'hD8);
        add(0,0,1,2'd0, 0,0,0,0,8'h00);
        // flush after two chunks (chunk with flush is discarded), then 00,01,10,11 -> 1B
        add(1,0,1,2'd3, 0,1,0,0,8'h00);
        add(1,0,1,2'd1, 0,1,0,0,8'h00);
        add(1,1,1,2'd3, 0,0,0,0,8'h00);
        add(1,0,1,2'd0, 0,1,0,0,8'h00);
        add(1,0,1,2'd1, 0,1,0,0,8'h00);
        add(1,0,1,2'd2, 0,1,0,0,8'h00);
        add(1,0,1,2'd3, 1,0,0,1,8'h1B);
        add(0,0,1,2'd0, 0,0,0,0,8'h00);

        foreach (vecs[i]) begin
            d8_valid = vecs[i].valid; d8_flush = vecs[i].flush;
            d8_ready = vecs[i].ready; d8_data  = vecs[i].data;
            @(posedge clk); @(negedge clk);
            check($sformatf("vec%0d_valid", i), {31'd0, d8_vo},   {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_busy", i),  {31'd0, d8_busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_ovf", i),   {31'd0, d8_ovf},  {31'd0, vecs[i].exp_ovf});
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_data", i), {24'd0, d8_out}, {24'd0, vecs[i].exp_data});
            $display("vec %0d: v=%0b f=%0b r=%0b d=%0d -> valid=%0b busy=%0b data=%h",
                     i, vecs[i].valid, vecs[i].flush, vecs[i].ready, vecs[i].data,
                     d8_vo, d8_busy, d8_out);
        end
        d8_valid = 0; d8_flush = 0;

        // 32/4: two back-to-back words with ready low -> first held, second dropped
        w = 32'h12345678;
        for (int k = 0; k < 8; k++) cyc32(1'b1, w[31-4*k -: 4], 1'b0, 1'b0);
        check("ovr_first_valid", {31'd0, d32_vo}, 32'h1);
        check("ovr_first_data",  d32_out, 32'h12345678);
        w = 32'h9ABCDEF0;
        for (int k = 0; k < 7; k++) cyc32(1'b1, w[31-4*k -: 4], 1'b0, 1'b0);
        check("ovr_before_last", {31'd0, d32_ovf}, 32'h0);
        cyc32(1'b1, w[3:0], 1'b0, 1'b0);
        check("ovr_sticky_set", {31'd0, d32_ovf}, 32'h1);
        check("ovr_held_data",  d32_out, 32'h12345678);
        check("ovr_busy_wrap",  {31'd0, d32_busy}, 32'h0);
        d32_valid = 0; d32_ready = 1'b1;
        check("ovr_hs_data", d32_out, 32'h12345678);
        @(posedge clk); @(negedge clk);
        check("ovr_hs_drop", {31'd0, d32_vo}, 32'h0);
        check("ovr_still_set", {31'd0, d32_ovf}, 32'h1);
        $display("overflow seq: handshake data=12345678 ovf=%0b", d32_ovf);
        cyc32(1'b0, 4'h0, 1'b0, 1'b1);
        check("ovr_flush_clr", {31'd0, d32_ovf}, 32'h0);

        // Held word; handshake coincides with next completion -> replaced, no overflow
        w = 32'hCAFEBABE;
        for (int k = 0; k < 8; k++) cyc32(1'b1, w[31-4*k -: 4], 1'b0, 1'b0);
        w = 32'h01234567;
        for (int k = 0; k < 7; k++) cyc32(1'b1, w[31-4*k -: 4], 1'b0, 1'b0);
        check("same_stable_data", d32_out, 32'hCAFEBABE);
        cyc32(1'b1, w[3:0], 1'b1, 1'b0);
        check("same_valid", {31'd0, d32_vo}, 32'h1);
        check("same_data",  d32_out, 32'h01234567);
        check("same_ovf",   {31'd0, d32_ovf}, 32'h0);
        cyc32(1'b0, 4'h0, 1'b1, 1'b0);
        check("same_drain", {31'd0, d32_vo}, 32'h0);
        $display("same-cycle seq: data=%h ovf=%0b", d32_out, d32_ovf);
        d32_ready = 0;

        // 8/2: hold a word, start another, then reset asynchronously
        cyc8(1'b1, 2'd3, 1'b0); cyc8(1'b1, 2'd1, 1'b0);
        cyc8(1'b1, 2'd2, 1'b0); cyc8(1'b1, 2'd0, 1'b0);
        cyc8(1'b1, 2'd1, 1'b0); cyc8(1'b1, 2'd1, 1'b0); cyc8(1'b1, 2'd1, 1'b0);
        check("pre_rst_valid", {31'd0, d8_vo}, 32'h1);
        check("pre_rst_busy",  {31'd0, d8_busy}, 32'h1);
        d8_valid = 0;
        reset = 1'b1;
        #1;
        check("rst_async_valid", {31'd0, d8_vo},   32'h0);
        check("rst_async_busy",  {31'd0, d8_busy}, 32'h0);
        check("rst_async_data",  {24'd0, d8_out},  32'h0);
        check("rst_async_ovf",   {31'd0, d8_ovf},  32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc8(1'b1, 2'd2, 1'b1); cyc8(1'b1, 2'd1, 1'b1);
        cyc8(1'b1, 2'd3, 1'b1); cyc8(1'b1, 2'd0, 1'b1);
        check("post_rst_valid", {31'd0, d8_vo}, 32'h1);
        check("post_rst_data",  {24'd0, d8_out}, 32'h9C);
        $display("reset seq: new word data=%h", d8_out);
        cyc8(1'b0, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
